// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg
//   Shared definitions for the one-hot encoder / decoder pair.
//   Both ends import this package so the bit order of the 3-bit code
//   (bit 2 = encoder Y0 / MSB, bit 0 = encoder Y2 / LSB) and the one-hot
//   word (bit n set for code n) is defined in exactly one place.
package onehot_dec_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;

  typedef logic [CODE_W-1:0]   code_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  // 3-to-8 decode: bit n of the result is set for code n.
  function automatic onehot_t decode_code(input code_t code);
    onehot_t word;
    word       = '0;
    word[code] = 1'b1;
    return word;
  endfunction

  // 8-to-3 encode used on the transmit side. If several bits are set the
  // highest one wins; an all-zero word encodes as 0.
  function automatic code_t encode_onehot(input onehot_t word);
    code_t code;
    code = '0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      if (word[i]) begin
        code = CODE_W'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// code_fifo
//   Synchronous FIFO of WIDTH-bit entries with a combinational view of the
//   head entry, so the consumer sees the oldest entry in the same cycle
//   that level becomes non-zero.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset (pointers and level only)
//   push     write wr_data at the tail (caller guarantees not full)
//   pop      drop the head entry (caller guarantees not empty)
//   wr_data  entry to store
//   rd_data  head entry (meaningless while level == 0)
//   level    current occupancy, 0..DEPTH
module code_fifo
  import onehot_dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1,
  parameter int WIDTH = CODE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] level_reg;
  logic [CNT_W-1:0] level_next;

  // Storage needs no reset: an entry is only read after it was written,
  // because the level gates every pop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_next;
    end
  end

  // Push and pop together leave the occupancy unchanged.
  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign level   = level_reg;

endmodule

// File: rtl/onehot_decoder_pipe.sv
// onehot_decoder_pipe
//   Streaming 3-to-8 decoder. Codes arrive over a valid/ready handshake,
//   are buffered as 3-bit values in code_fifo, and the head entry is
//   decoded to a one-hot word on the output handshake.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_code is valid
//   in_ready   a code can be accepted (FIFO not full)
//   in_code    3-bit code, bit 2 = encoder Y0
//   out_valid  out_onehot holds a decoded word (FIFO not empty)
//   out_ready  consumer accepts the word
//   out_onehot decoded word, 8'h00 while out_valid is low
//   level      FIFO occupancy
// Every output is a function of registered FIFO state only, so there is
// no combinational path from an input to an output.
module onehot_decoder_pipe
  import onehot_dec_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic [CNT_W-1:0]    level
);

  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(DEPTH);

  logic        push;
  logic        pop;
  code_t       head_code;

  // Ready and valid come straight from the occupancy. When full, in_ready
  // is low even if a pop is happening this cycle; the push lands on the
  // following edge instead.
  assign in_ready  = (level != FULL_LEVEL);
  assign out_valid = (level != '0);

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  code_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W),
    .WIDTH (CODE_W)
  ) u_code_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (in_code),
    .rd_data (head_code),
    .level   (level)
  );

  // Masking keeps the stale/unwritten head entry from leaking out while
  // the FIFO is empty, so an all-zero word means "nothing here".
  assign out_onehot = out_valid ? decode_code(head_code) : '0;

endmodule
